// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// reset PC default and the word-alignment check.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetchState_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [1:0]  ALIGN_MASK       = 2'b11;

  function automatic logic isAligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_pc_register.sv
// Program counter register: synchronous reset to RESET_PC, loads i_d when
// i_load is high, otherwise holds its value.
module pc_register
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: requests the word at the current PC, holds it until
// the core commits, then advances to next_pc or traps on a misaligned target.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic        misalign,
  output logic [31:0] fault_pc,
  output logic [31:0] commit_cnt
);

  fetchState_e r_state;
  fetchState_e w_nextState;

  logic        w_capture;
  logic        w_commit;
  logic        w_pcLoad;
  logic        w_fault;
  logic        w_targetAligned;
  logic [31:0] w_pc;
  logic [31:0] r_inst;
  logic [31:0] r_faultPc;
  logic [31:0] r_commitCnt;

  assign w_targetAligned = isAligned(next_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_REQ:   if (imem_ready)  w_nextState = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) w_nextState = ST_HOLD;
      ST_HOLD:  if (pc_en)       w_nextState = w_targetAligned ? ST_REQ : ST_FAULT;
      ST_FAULT: w_nextState = ST_FAULT;
      default:  w_nextState = ST_REQ;
    endcase
  end

  // Read data and commit strobes only matter in their own state, which is
  // what makes stray rvalid and pc_en pulses harmless elsewhere.
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    misalign   = 1'b0;
    w_capture  = 1'b0;
    w_commit   = 1'b0;
    w_pcLoad   = 1'b0;
    w_fault    = 1'b0;
    case (r_state)
      ST_REQ:   imem_req = 1'b1;
      ST_WAIT:  w_capture = imem_rvalid;
      ST_HOLD: begin
        inst_valid = 1'b1;
        w_commit   = pc_en;
        w_pcLoad   = pc_en && w_targetAligned;
        w_fault    = pc_en && !w_targetAligned;
      end
      ST_FAULT: misalign = 1'b1;
      default:  imem_req = 1'b0;
    endcase
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pcReg (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_pcLoad),
    .i_d    (next_pc),
    .o_q    (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst    <= '0;
      r_faultPc <= '0;
    end else begin
      if (w_capture) r_inst <= imem_rdata;
      if (w_fault)   r_faultPc <= next_pc;
    end
  end

  // Both aligned and misaligned commits count; the counter wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commitCnt <= '0;
    end else if (w_commit) begin
      r_commitCnt <= r_commitCnt + 32'd1;
    end
  end

  assign imem_addr  = w_pc;
  assign pc_out     = w_pc;
  assign inst       = r_inst;
  assign fault_pc   = r_faultPc;
  assign commit_cnt = r_commitCnt;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 next_pc  input  32  next instruction address from the next-address stage.
REQ-005 pc_en  input  1  commit strobe: current instruction finished, load next_pc.
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  32  fetch address (current PC).
REQ-008 imem_ready  input  1  memory accepts request this cycle.
REQ-009 imem_rvalid  input  1  read data valid.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 inst_valid  output  1  inst/pc_out hold a fetched instruction.
REQ-012 inst  output  32  fetched instruction word.
REQ-013 pc_out  output  32  PC of inst; also feeds currentPC of the next-address stage.
REQ-014 misalign  output  1  sticky fault: committed next_pc[1:0] != 0.
REQ-015 fault_pc  output  32  offending next_pc captured at fault.
REQ-016 commit_cnt  output  32  count of accepted commits.

Function
REQ-017 States SHALL be REQ, WAIT, HOLD, FAULT, registered; outputs decoded from state and registers.
REQ-018 REQ: imem_req=1, imem_addr=pc; imem_ready=1 -> WAIT next cycle; otherwise remain in REQ with pc stable.
REQ-019 WAIT: imem_req=0; imem_rvalid=1 -> inst<=imem_rdata, inst_valid<=1, -> HOLD; otherwise remain.
REQ-020 imem_rvalid SHALL be ignored outside WAIT; memory latency is at least 1 cycle after acceptance.
REQ-021 HOLD: inst, pc_out, inst_valid stable until pc_en=1.
REQ-022 HOLD with pc_en=1 and next_pc[1:0]==0: pc<=next_pc, inst_valid<=0, commit_cnt+=1, -> REQ.
REQ-023 HOLD with pc_en=1 and next_pc[1:0]!=0: misalign<=1, fault_pc<=next_pc, inst_valid<=0, commit_cnt+=1, pc unchanged, -> FAULT.
REQ-024 FAULT is absorbing until rst; imem_req=0, inst_valid=0.
REQ-025 pc_en outside HOLD SHALL be ignored (no pc, counter, or state change).
REQ-026 commit_cnt wraps 32'hFFFF_FFFF -> 0 without side effect.
REQ-027 Latency with 1-cycle memory: request accepted cycle N, rvalid N+1, inst_valid high N+2; commit in HOLD -> imem_req high the next cycle.
REQ-028 pc_out SHALL always equal the internal pc register; next_pc is 32-bit, no truncation.

Reset
REQ-029 rst=1 at a clock edge: pc=RESET_PC, state=REQ, inst=0, inst_valid=0, misalign=0, fault_pc=0, commit_cnt=0.
REQ-030 rst in any state, including WAIT with a request outstanding, SHALL abandon that request; memory shares rst, so no stale response follows.
REQ-031 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.

Structure
REQ-032 Shared package holds the state enumeration, the RESET_PC default, and the 2-bit alignment mask constant.
REQ-033 One sub-module, pc_register: 32-bit register with synchronous reset to RESET_PC and load enable.

Verification
REQ-034 Reset, imem_ready=1, 1-cycle memory returning 32'h0000_0013 -> imem_addr=8000_0000 in cycle 0, inst_valid=1 and inst=0000_0013 in cycle 2.
REQ-035 HOLD, pc_en=1, next_pc=8000_0004 -> pc_out=8000_0004, commit_cnt=1, imem_req=1 the next cycle.
REQ-036 imem_ready held 0 for 3 cycles -> imem_req stays 1 and imem_addr stays constant; pc_en pulsed during this time -> ignored.
REQ-037 HOLD, pc_en=1, next_pc=8000_0006 -> misalign=1, fault_pc=8000_0006, imem_req=0 until rst.
REQ-038 rst asserted in WAIT, then a late rvalid is suppressed -> after reset imem_addr=8000_0000 and inst_valid=0 until a fresh response.
REQ-039 commit_cnt preloaded near wrap (force to FFFF_FFFF), one commit -> 0000_0000.
